// File: rtl/spi_host_master.sv
// rtl/spi_host_master.sv - SPI initiator serialising register read/write commands into CSN/MOSI frames
module spi_host_master #(
  parameter int FRAME_LEN = 34,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int RD_START  = 16,
  parameter int IDLE_GAP  = 2
) (
  input  logic              SCLK,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              MISO,
  output logic              CSN,
  output logic              MOSI,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata
);

  if ((1 + ADDR_W + DATA_W > FRAME_LEN) || (RD_START + DATA_W > FRAME_LEN) || (IDLE_GAP < 1)) begin : g_param_check
    $error("spi_host_master: illegal frame geometry");
  end

  localparam int KW = $clog2(FRAME_LEN + 1);
  localparam int GW = $clog2(IDLE_GAP + 1);
  // With a one-posedge gap the IDLE cycle itself provides the CSN-high posedge.
  localparam bit SKIP_GAP = (IDLE_GAP < 2);
  localparam int GAP_LAST = SKIP_GAP ? 0 : IDLE_GAP - 2;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [FRAME_LEN-1:0]  sr_q, sr_d;
  logic                  rw_q, rw_d;
  logic [DATA_W-1:0]     cap_q, cap_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                  csn_q, csn_d;
  logic                  mosi_q, mosi_d;
  logic [FRAME_LEN-1:0]  frame_vec;
  logic                  in_window;

  // Assemble the outgoing frame with bit 0 (R/W) at the MSB so it shifts out first.
  always_comb begin
    frame_vec = '0;
    frame_vec[FRAME_LEN-1] = cmd_rw;
    frame_vec[FRAME_LEN-2 -: ADDR_W] = cmd_addr;
    if (cmd_rw) begin
      frame_vec[FRAME_LEN-2-ADDR_W -: DATA_W] = cmd_wdata;
    end
  end

  assign in_window = (k_q >= KW'(RD_START)) && (k_q < KW'(RD_START + DATA_W));

  // Next-state logic for the posedge stage: accept, shift/capture, then enforce the CSN-high gap.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    gap_d       = gap_q;
    sr_d        = sr_q;
    rw_d        = rw_q;
    cap_d       = cap_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = SHIFT;
          sr_d    = frame_vec;
          rw_d    = cmd_rw;
          k_d     = '0;
          cap_d   = '0;
        end
      end
      SHIFT: begin
        sr_d = {sr_q[FRAME_LEN-2:0], 1'b0};
        if (!rw_q && in_window) begin
          cap_d = {cap_q[DATA_W-2:0], MISO};
        end
        if (k_q == KW'(FRAME_LEN - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rw_q ? '0 : cap_d;
          gap_d       = '0;
          state_d     = SKIP_GAP ? IDLE : GAP;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_LAST)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
  end

  // Posedge state machine with registered handshake and response outputs.
  always_ff @(posedge SCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      gap_q       <= '0;
      sr_q        <= '0;
      rw_q        <= 1'b0;
      cap_q       <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      gap_q       <= gap_d;
      sr_q        <= sr_d;
      rw_q        <= rw_d;
      cap_q       <= cap_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Pin values for the negedge stage come straight from posedge-stage state so they never glitch.
  always_comb begin
    csn_d  = (state_q != SHIFT);
    mosi_d = (state_q == SHIFT) && sr_q[FRAME_LEN-1];
  end

  // Negedge output stage keeps CSN/MOSI stable across the slave's sampling posedge.
  always_ff @(negedge SCLK or negedge rst_n) begin
    if (!rst_n) begin
      csn_q  <= 1'b1;
      mosi_q <= 1'b0;
    end else begin
      csn_q  <= csn_d;
      mosi_q <= mosi_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign CSN       = csn_q;
  assign MOSI      = mosi_q;

endmodule
